alu_issue_wb: RTL and testbench

Sequencer that sits directly around the 4-bit combinational ALU. It takes commands from a valid/ready interface and reads operands from a small internal register file. It drives the ALU's a/b/op inputs from registers, then captures result and carry back into the register file and a flag register. All commands run one at a time, so there are no read-after-write hazards.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_issue_wb_if.sv | 41 ++++
 rtl/alu_regfile.sv | 52 +++++
 rtl/alu_issue_wb.sv | 142 ++++++++++++++
 tb/tb_alu_issue_wb.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared types and constants for the ALU issue/writeback sequencer.
//   Contents:
//     DATA_W         operand/result width (matches the external 4-bit ALU)
//     alu_op_e       the eight ALU opcodes
//     issue_state_e  sequencer states
//     cmd_t          command record {op, rd, rs1, rs2} for the default 4-register build
package alu_pkg;

  localparam int DATA_W      = 4;
  localparam int NREG_DEF    = 4;
  localparam int REG_AW_DEF  = $clog2(NREG_DEF);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } issue_state_e;

  typedef struct packed {
    alu_op_e               op;
    logic [REG_AW_DEF-1:0] rd;
    logic [REG_AW_DEF-1:0] rs1;
    logic [REG_AW_DEF-1:0] rs2;
  } cmd_t;

endpackage

// File: rtl/alu_issue_wb_if.sv
// alu_issue_wb_if
//   Command and register-load handshake channels of the sequencer.
//   Signals:
//     cmd_valid/cmd_ready  command handshake
//     cmd_op/rd/rs1/rs2    command fields
//     ld_valid/ld_ready    direct register load handshake
//     ld_reg/ld_data       load destination and value
//   Modports:
//     master  requester side (drives valid and payload)
//     slave   sequencer side (drives ready)
interface alu_issue_wb_if #(
  parameter int NREG = 4
);
  import alu_pkg::*;

  localparam int REG_AW = $clog2(NREG);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_rs1;
  logic [REG_AW-1:0] cmd_rs2;
  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_reg;
  logic [DATA_W-1:0] ld_data;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
    output ld_valid, ld_reg, ld_data,
    input  cmd_ready, ld_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
    input  ld_valid, ld_reg, ld_data,
    output cmd_ready, ld_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// alu_regfile
//   NREG x DATA_W architectural register file built from flops.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (clears all registers)
//     we/waddr/wdata  single write port (load/writeback muxing is done by the parent)
//     ra1/rd1         combinational read port for ALU operand a
//     ra2/rd2         combinational read port for ALU operand b
//     ra3/rd3         combinational debug read port
module alu_regfile
  import alu_pkg::*;
#(
  parameter  int NREG   = 4,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic [REG_AW-1:0] ra3,
  output logic [DATA_W-1:0] rd3
);

  logic [DATA_W-1:0] regs_reg [NREG];
  logic [NREG-1:0]   wen;

  // One-hot write enable per register.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_wen
      assign wen[gi] = we && (waddr == REG_AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) begin
        regs_reg[i] <= '0;
      end else if (wen[i]) begin
        regs_reg[i] <= wdata;
      end
    end
  end

  assign rd1 = regs_reg[ra1];
  assign rd2 = regs_reg[ra2];
  assign rd3 = regs_reg[ra3];

endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb
//   Sequencer wrapped around an external combinational 4-bit ALU. Accepts
//   commands and direct register loads, drives registered ALU operands, then
//   writes the result back into the register file and updates the flags.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     bus (slave)         command and load handshake channels
//     alu_a/alu_b/alu_op  registered ALU inputs (held until the next accept)
//     alu_result/carry    combinational ALU outputs
//     rd_sel/rd_data      combinational debug read port
//     flag_c/flag_z       carry and zero of the last written-back command
//     done                one-cycle pulse during the writeback cycle
//     busy                sequencer is not idle
//   Build option:
//     ALU_ISSUE_BYPASS_EN  drop the EXEC state; WB takes the ALU output directly
//                          (accept to writeback in 2 edges instead of 3)
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter  int NREG   = 4,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_wb_if.slave     bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic [REG_AW-1:0] rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              flag_c,
  output logic              flag_z,
  output logic              done,
  output logic              busy
);

  issue_state_e      state;
  logic [REG_AW-1:0] rd_lat;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              idle;
  logic              ld_fire;
  logic              cmd_fire;
  logic              wb_en;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] wb_result;
  logic              wb_carry;

  assign idle         = (state == ST_IDLE);
  assign bus.ld_ready  = idle;
  // A pending load always takes the idle slot ahead of a command.
  assign bus.cmd_ready = idle && !bus.ld_valid;
  assign ld_fire       = idle && bus.ld_valid;
  assign cmd_fire      = idle && !bus.ld_valid && bus.cmd_valid;
  assign busy          = !idle;
  assign wb_en         = (state == ST_WB);

`ifdef ALU_ISSUE_BYPASS_EN
  // The ALU output is consumed straight into writeback.
  assign wb_result = alu_result;
  assign wb_carry  = alu_carry;
`else
  logic [DATA_W-1:0] hold_result_reg;
  logic              hold_carry_reg;
  assign wb_result = hold_result_reg;
  assign wb_carry  = hold_carry_reg;
`endif

  // Loads and writeback never coincide: loads only fire in IDLE.
  assign rf_we    = ld_fire || wb_en;
  assign rf_waddr = wb_en ? rd_lat : bus.ld_reg;
  assign rf_wdata = wb_en ? wb_result : bus.ld_data;

  alu_regfile #(.NREG(NREG)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .ra1   (bus.cmd_rs1),
    .rd1   (rs1_data),
    .ra2   (bus.cmd_rs2),
    .rd2   (rs2_data),
    .ra3   (rd_sel),
    .rd3   (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      rd_lat <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b1;
      done   <= 1'b0;
`ifndef ALU_ISSUE_BYPASS_EN
      hold_result_reg <= '0;
      hold_carry_reg  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            // Operands are latched here, so rd == rs1/rs2 is safe.
            alu_a  <= rs1_data;
            alu_b  <= rs2_data;
            alu_op <= bus.cmd_op;
            rd_lat <= bus.cmd_rd;
`ifdef ALU_ISSUE_BYPASS_EN
            state <= ST_WB;
            done  <= 1'b1;
`else
            state <= ST_EXEC;
`endif
          end
        end
`ifndef ALU_ISSUE_BYPASS_EN
        ST_EXEC: begin
          hold_result_reg <= alu_result;
          hold_carry_reg  <= alu_carry;
          state           <= ST_WB;
          done            <= 1'b1;
        end
`endif
        ST_WB: begin
          flag_c <= wb_carry;
          flag_z <= (wb_result == '0);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
`timescale 1ns/1ps
module tb_alu_issue_wb;
  import alu_pkg::*;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_a, alu_b, alu_result, rd_data;
  logic [2:0] alu_op;
  logic       alu_carry;
  logic [1:0] rd_sel;
  logic       flag_c, flag_z, done, busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: architectural registers and flags.
  int mregs [4];
  int mfc;
  int mfz;

  alu_issue_wb_if #(.NREG(4)) bus_if ();

  alu_issue_wb #(.NREG(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Arithmetic meaning of each opcode on 4-bit values: {carry, result}.
  function automatic logic [4:0] ref_alu(input int op, input int a, input int b);
    int r;
    int c;
    c = 0;
    case (op)
      0: begin r = a + b; c = (r > 15) ? 1 : 0; end
      1: begin r = a - b; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: r = a * 2;
      7: r = a / 2;
      default: r = 0;
    endcase
    r = r & 15;
    return {c[0], r[3:0]};
  endfunction

  // External combinational ALU the sequencer drives.
  always_comb begin
    logic [4:0] v;
    v = ref_alu(int'(alu_op), int'(alu_a), int'(alu_b));
    alu_carry  = v[4];
    alu_result = v[3:0];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 8'(rd_data), 8'(mregs[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    mfc = 0;
    mfz = 1;
  endtask

  task automatic do_load(input int r, input int d);
    int w;
    bus_if.ld_valid = 1'b1;
    bus_if.ld_reg   = 2'(r);
    bus_if.ld_data  = 4'(d);
    w = 0;
    #1;
    while (!bus_if.ld_ready && w < 10) begin tick(); w++; end
    chk("ld_wait", 8'(w < 10), 8'd1);
    tick();
    bus_if.ld_valid = 1'b0;
    mregs[r] = d & 15;
    rd_sel = 2'(r);
    #1;
    $display("load r%0d <= %0h : rd_data=%0h", r, d, rd_data);
    chk("ld_data", 8'(rd_data), 8'(mregs[r]));
    chk("ld_flag_c", 8'(flag_c), 8'(mfc));
    chk("ld_flag_z", 8'(flag_z), 8'(mfz));
  endtask

  task automatic do_cmd(input int op, input int rd, input int rs1, input int rs2);
    int a, b, w;
    logic [4:0] e;
    a = mregs[rs1];
    b = mregs[rs2];
    e = ref_alu(op, a, b);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = 3'(op);
    bus_if.cmd_rd    = 2'(rd);
    bus_if.cmd_rs1   = 2'(rs1);
    bus_if.cmd_rs2   = 2'(rs2);
    w = 0;
    #1;
    while (!bus_if.cmd_ready && w < 10) begin tick(); w++; end
    chk("cmd_wait", 8'(w < 10), 8'd1);
    tick();
    bus_if.cmd_valid = 1'b0;
    chk("exec_busy", 8'(busy), 8'd1);
    chk("exec_alu_a", 8'(alu_a), 8'(a));
    chk("exec_alu_b", 8'(alu_b), 8'(b));
    chk("exec_alu_op", 8'(alu_op), 8'(op));
    chk("exec_cmd_ready", 8'(bus_if.cmd_ready), 8'd0);
    chk("exec_ld_ready", 8'(bus_if.ld_ready), 8'd0);
    for (int k = 0; k < LAT; k++) begin
      if (k > 0) tick();
      chk($sformatf("done_c%0d", k), 8'(done), 8'(k == LAT - 1));
    end
    tick();
    mregs[rd] = int'(e[3:0]);
    mfc = int'(e[4]);
    mfz = (e[3:0] == 4'd0) ? 1 : 0;
    $display("cmd op=%0d r%0d <= r%0d(%0h),r%0d(%0h) : exp=%0h c=%0d z=%0d got c=%0d z=%0d",
             op, rd, rs1, a, rs2, b, e[3:0], mfc, mfz, flag_c, flag_z);
    chk("wb_done_low", 8'(done), 8'd0);
    chk("wb_busy", 8'(busy), 8'd0);
    chk("wb_flag_c", 8'(flag_c), 8'(mfc));
    chk("wb_flag_z", 8'(flag_z), 8'(mfz));
    chk("hold_alu_a", 8'(alu_a), 8'(a));
    chk("hold_alu_b", 8'(alu_b), 8'(b));
    check_all_regs("wb");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = '0;
    bus_if.cmd_rd    = '0;
    bus_if.cmd_rs1   = '0;
    bus_if.cmd_rs2   = '0;
    bus_if.ld_valid  = 1'b0;
    bus_if.ld_reg    = '0;
    bus_if.ld_data   = '0;
    rd_sel = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state.
    $display("reset state check");
    check_all_regs("rst");
    chk("rst_flag_z", 8'(flag_z), 8'd1);
    chk("rst_flag_c", 8'(flag_c), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_cmd_ready", 8'(bus_if.cmd_ready), 8'd1);
    chk("rst_ld_ready", 8'(bus_if.ld_ready), 8'd1);
    chk("rst_alu_a", 8'(alu_a), 8'd0);
    chk("rst_alu_b", 8'(alu_b), 8'd0);
    chk("rst_alu_op", 8'(alu_op), 8'd0);

    // 9 + 8 -> 1 with carry.
    do_load(0, 9);
    do_load(1, 8);
    do_cmd(OP_ADD, 2, 0, 1);
    // 3 - 5 -> 0xE with borrow.
    do_load(0, 3);
    do_load(1, 5);
    do_cmd(OP_SUB, 3, 0, 1);
    // Self-overwrite: r0 = r0 ^ r1 = 0.
    do_load(0, 10);
    do_load(1, 10);
    do_cmd(OP_XOR, 0, 0, 1);

    // Load and command offered together: load goes first.
    bus_if.ld_valid  = 1'b1;
    bus_if.ld_reg    = 2'd1;
    bus_if.ld_data   = 4'd7;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = 3'(OP_OR);
    bus_if.cmd_rd    = 2'd2;
    bus_if.cmd_rs1   = 2'd0;
    bus_if.cmd_rs2   = 2'd1;
    #1;
    chk("both_cmd_ready", 8'(bus_if.cmd_ready), 8'd0);
    chk("both_ld_ready", 8'(bus_if.ld_ready), 8'd1);
    tick();
    bus_if.ld_valid = 1'b0;
    mregs[1] = 7;
    #1;
    $display("simultaneous load+cmd: load taken, busy=%0d", busy);
    chk("both_no_accept", 8'(busy), 8'd0);
    chk("both_cmd_ready_next", 8'(bus_if.cmd_ready), 8'd1);
    do_cmd(OP_OR, 2, 0, 1);

    // Randomised loads and commands.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        do_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      else
        do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset while a command is in flight.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    do_load(0, 5);
    do_load(1, 6);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = 3'(OP_ADD);
    bus_if.cmd_rd    = 2'd3;
    bus_if.cmd_rs1   = 2'd0;
    bus_if.cmd_rs2   = 2'd1;
    #1;
    tick();
    bus_if.cmd_valid = 1'b0;
    chk("mid_busy", 8'(busy), 8'd1);
`ifndef ALU_ISSUE_BYPASS_EN
    chk("mid_done", 8'(done), 8'd0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    $display("reset mid-command: busy=%0d done=%0d", busy, done);
    chk("midrst_done", 8'(done), 8'd0);
    chk("midrst_busy", 8'(busy), 8'd0);
    chk("midrst_cmd_ready", 8'(bus_if.cmd_ready), 8'd1);
    chk("midrst_flag_z", 8'(flag_z), 8'd1);
    chk("midrst_flag_c", 8'(flag_c), 8'd0);
    check_all_regs("midrst");
    tick();
    chk("midrst_no_late_done", 8'(done), 8'd0);
    chk("midrst_r3", 8'(dut.u_regfile.rd3 === rd_data), 8'd1);

    // Recovery after reset.
    do_load(0, 15);
    do_load(1, 1);
    do_cmd(OP_ADD, 3, 0, 1);
    do_cmd(OP_SHL, 1, 0, 0);
    do_cmd(OP_SHR, 2, 0, 0);
    do_cmd(OP_NOT, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
